// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ producers.
// Each grant lasts up to BURST_MAX words; priority rotates after every burst.
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned BURST_MAX = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic [NUM_REQ-1:0]        grant,
  input  logic                      fifo_full,
  output logic                      fifo_wr,
  output logic [DATA_W-1:0]         fifo_din,
  output logic                      busy
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(BURST_MAX - 1);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e              state_q;
  logic [IdxW-1:0]     owner_q;
  logic [IdxW-1:0]     last_owner_q;
  logic [CntW-1:0]     burst_cnt_q;
  logic [NUM_REQ-1:0]  grant_q;
  logic                busy_q;

  logic                any_req;
  logic [IdxW-1:0]     next_owner;
  logic                owner_req;

  // Scan upward from last_owner+1, wrapping, and take the first active request.
  always_comb begin
    int unsigned idx;
    any_req    = 1'b0;
    next_owner = '0;
    idx        = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = int'(last_owner_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!any_req && req[idx[IdxW-1:0]]) begin
        any_req    = 1'b1;
        next_owner = idx[IdxW-1:0];
      end
    end
  end

  assign owner_req = req[owner_q];
  assign fifo_wr   = ~reset & (state_q == StGrant) & owner_req & ~fifo_full;
  assign ack       = fifo_wr ? (NUM_REQ'(1) << owner_q) : '0;
  assign grant     = grant_q;
  assign busy      = busy_q;

  always_comb begin
    fifo_din = '0;
    if (!reset && state_q == StGrant) begin
      fifo_din = req_data[int'(owner_q) * DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      owner_q      <= '0;
      last_owner_q <= IdxW'(NUM_REQ - 1);
      burst_cnt_q  <= '0;
      grant_q      <= '0;
      busy_q       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            state_q     <= StGrant;
            owner_q     <= next_owner;
            grant_q     <= NUM_REQ'(1) << next_owner;
            burst_cnt_q <= '0;
            busy_q      <= 1'b1;
          end
        end
        StGrant: begin
          // Burst complete or owner released: rotate. A full FIFO only stalls.
          if ((fifo_wr && burst_cnt_q == LastCnt) || !owner_req) begin
            state_q      <= StIdle;
            last_owner_q <= owner_q;
            burst_cnt_q  <= '0;
            grant_q      <= '0;
            busy_q       <= 1'b0;
          end else if (fifo_wr) begin
            burst_cnt_q <= burst_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: vector table for rotation plus hand sequences
// for burst refill, stall, early release, async reset and single-word bursts.
module tb_fifo_wr_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  ack, grant;
  logic        fifo_full = 1'b0;
  logic        fifo_wr;
  logic [7:0]  fifo_din;
  logic        busy;

  logic [3:0]  b1_req = '0;
  logic [31:0] b1_data = '0;
  logic [3:0]  b1_ack, b1_grant;
  logic        b1_full;
  logic        b1_wr;
  logic [7:0]  b1_din;
  logic        b1_busy;
  int          b1_cnt = 0;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_W(8), .BURST_MAX(4)) u_dut (
    .clock(clock), .reset(reset), .req(req), .req_data(req_data), .ack(ack),
    .grant(grant), .fifo_full(fifo_full), .fifo_wr(fifo_wr), .fifo_din(fifo_din),
    .busy(busy)
  );

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_W(8), .BURST_MAX(1)) u_b1 (
    .clock(clock), .reset(reset), .req(b1_req), .req_data(b1_data), .ack(b1_ack),
    .grant(b1_grant), .fifo_full(b1_full), .fifo_wr(b1_wr), .fifo_din(b1_din),
    .busy(b1_busy)
  );

  // 32-entry FIFO occupancy model for the BURST_MAX=1 instance
  assign b1_full = (b1_cnt == 32);
  always @(posedge clock) if (b1_wr) b1_cnt <= b1_cnt + 1;

  typedef struct {
    logic [3:0] req;
    logic [3:0] grant;
    logic       wr;
    logic [3:0] ack;
    logic [7:0] din;
    logic       busy;
  } vec_t;

  vec_t vecs [22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Leaves the bench 1 time unit after a rising edge with reset released.
  task automatic do_reset();
    req = '0; fifo_full = 1'b0; b1_req = '0;
    reset = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] dins [4];
    int         n;
    bit         exp_wr1 [10];
    logic [3:0] exp_gr1 [10];
    bit         exp_wr2 [9];
    logic [3:0] exp_gr2 [9];
    logic [3:0] req3 [6];
    logic [3:0] exp_gr3 [6];
    bit         exp_wr3 [6];
    logic [7:0] d;
    bit         acked;
    int         writes;

    dins = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
    // All four requesting: idle, 4 writes per owner, rotating 0,1,2,3,0.
    n = 0;
    for (int b = 0; b < 5; b++) begin
      vecs[n] = '{req: 4'hF, grant: 4'h0, wr: 1'b0, ack: 4'h0, din: 8'h00, busy: 1'b0};
      n++;
      for (int w = 0; w < 4; w++) begin
        if (n < 22) begin
          vecs[n] = '{req: 4'hF, grant: 4'(1 << (b % 4)), wr: 1'b1, ack: 4'(1 << (b % 4)),
                      din: dins[b % 4], busy: 1'b1};
          n++;
        end
      end
    end

    exp_wr1 = '{0, 1, 1, 1, 1, 0, 1, 1, 0, 0};
    exp_gr1 = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h1, 4'h1, 4'h1, 4'h0};
    exp_wr2 = '{0, 1, 1, 0, 0, 0, 1, 1, 0};
    exp_gr2 = '{4'h0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0};
    req3    = '{4'hA, 4'hA, 4'hA, 4'h9, 4'h9, 4'h9};
    exp_gr3 = '{4'h0, 4'h2, 4'h2, 4'h2, 4'h0, 4'h8};
    exp_wr3 = '{0, 1, 1, 0, 0, 1};

    // Reset state
    #2;
    check("reset grant", grant, 4'h0);
    check("reset busy", busy, 1'b0);
    check("reset fifo_wr", fifo_wr, 1'b0);
    do_reset();

    // Rotation table
    req_data = 32'hD3C2B1A0;
    for (int i = 0; i < 22; i++) begin
      req = vecs[i].req;
      #2;
      check($sformatf("rot%0d grant", i), grant, vecs[i].grant);
      check($sformatf("rot%0d wr", i), fifo_wr, vecs[i].wr);
      check($sformatf("rot%0d ack", i), ack, vecs[i].ack);
      check($sformatf("rot%0d din", i), fifo_din, vecs[i].din);
      check($sformatf("rot%0d busy", i), busy, vecs[i].busy);
      @(posedge clock); #1;
    end

    // Single requester, data advanced on ack: 10..13, idle, 14, 15, release
    do_reset();
    d = 8'h10;
    for (int c = 0; c < 10; c++) begin
      req_data = {24'h0, d};
      req = (d <= 8'h15) ? 4'h1 : 4'h0;
      #2;
      check($sformatf("seq%0d wr", c), fifo_wr, exp_wr1[c]);
      check($sformatf("seq%0d grant", c), grant, exp_gr1[c]);
      acked = fifo_wr;
      if (fifo_wr) begin
        check($sformatf("seq%0d din", c), fifo_din, d);
        check($sformatf("seq%0d ack", c), ack, 4'h1);
      end
      @(posedge clock); #1;
      if (acked) d++;
    end
    check("seq words written", d, 8'h16);

    // Stall: FIFO full for 3 cycles after the 2nd write
    do_reset();
    req_data = 32'h00770000;
    writes = 0;
    for (int c = 0; c < 9; c++) begin
      req = 4'h4;
      fifo_full = (c >= 3 && c <= 5);
      #2;
      check($sformatf("stall%0d wr", c), fifo_wr, exp_wr2[c]);
      check($sformatf("stall%0d grant", c), grant, exp_gr2[c]);
      check($sformatf("stall%0d ack", c), ack, exp_wr2[c] ? 4'h4 : 4'h0);
      if (fifo_wr) writes++;
      @(posedge clock); #1;
    end
    fifo_full = 1'b0;
    check("stall total writes", writes, 4);

    // Early release by owner 1; next scan starts at 2 so 3 beats 0
    do_reset();
    req_data = 32'h44332211;
    for (int c = 0; c < 6; c++) begin
      req = req3[c];
      #2;
      check($sformatf("rel%0d grant", c), grant, exp_gr3[c]);
      check($sformatf("rel%0d wr", c), fifo_wr, exp_wr3[c]);
      if (c == 5) begin
        check("rel ack", ack, 4'h8);
        check("rel din", fifo_din, 8'h44);
      end
      @(posedge clock); #1;
    end

    // Asynchronous reset mid-burst
    do_reset();
    req = 4'hF;
    req_data = 32'hD3C2B1A0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    #2;
    check("arst pre wr", fifo_wr, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("arst wr", fifo_wr, 1'b0);
    check("arst ack", ack, 4'h0);
    check("arst grant", grant, 4'h0);
    check("arst busy", busy, 1'b0);
    check("arst din", fifo_din, 8'h00);
    req = 4'h3;
    @(posedge clock); #1;
    reset = 1'b0;
    #2;
    check("arst idle grant", grant, 4'h0);
    @(posedge clock); #1;
    check("arst regrant", grant, 4'h1);
    check("arst regrant wr", fifo_wr, 1'b1);
    check("arst regrant din", fifo_din, 8'hA0);

    // BURST_MAX=1: write, idle alternating until the 32-deep FIFO fills
    do_reset();
    b1_req = 4'h1;
    b1_data = 32'h00000055;
    for (int c = 0; c < 80; c++) begin
      #2;
      check($sformatf("b1 cyc%0d wr", c), b1_wr, ((c % 2) == 1) && (c < 64));
      check($sformatf("b1 cyc%0d wr&full", c), b1_wr & b1_full, 1'b0);
      @(posedge clock); #1;
    end
    #2;
    check("b1 fifo count", b1_cnt, 32);
    check("b1 stalled wr", b1_wr, 1'b0);
    check("b1 grant held", b1_grant, 4'h1);
    check("b1 busy held", b1_busy, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
